// File: rtl/sysarray_pkg.sv
// Shared constants and FSM state encoding for the 3x3 systolic-array operand feeder.
package sysarray_pkg;

    localparam int N             = 3;
    localparam int A_W_DEF       = 8;
    localparam int B_W_DEF       = 8;
    localparam int K_MAX_DEF     = 16;
    localparam int DRAIN_CYC_DEF = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/sysarray_feeder_skew_line.sv
// skew_line: DEPTH-stage shift register for one feeder lane.
// Stage 0 takes din every cycle. Later stages shift every cycle.
// rst or flush zeroes every stage.
module skew_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_r [DEPTH];

    // Shift the lane one stage per cycle; reset and flush empty the whole line
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            stage_r[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/sysarray_feeder.sv
// sysarray_feeder: feeds A columns and B rows into a 3x3 output-stationary systolic array.
// Lane i is delayed by i cycles. A job runs IDLE -> CLEAR -> FEED -> DRAIN -> DONE.
// Optional feature: define SYSARRAY_FEEDER_STALL_CNT_EN to build the FEED stall counter.
// Without that macro, stall_cnt is tied to zero.
module sysarray_feeder
    import sysarray_pkg::*;
#(
    parameter int A_W       = A_W_DEF,
    parameter int B_W       = B_W_DEF,
    parameter int K_MAX     = K_MAX_DEF,
    parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [A_W-1:0] a_col [0:N-1],
    input  logic signed [B_W-1:0] b_row [0:N-1],
    input  logic                  in_last,
    output logic signed [A_W-1:0] left  [0:N-1],
    output logic signed [B_W-1:0] top   [0:N-1],
    output logic                  clr,
    output logic                  busy,
    output logic                  done,
    output logic                  err_ovf,
    output logic [15:0]           stall_cnt
);

    localparam int CNT_W = $clog2(K_MAX + 1);
    localparam int DR_W  = $clog2(DRAIN_CYC + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(K_MAX - 1);
    localparam logic [DR_W-1:0]  DRAIN_LAST = DR_W'(DRAIN_CYC - 1);

    state_e           state_r, next_s;
    logic [CNT_W-1:0] beat_cnt_r;
    logic [DR_W-1:0]  drain_cnt_r;
    logic             in_ready_r, clr_r, busy_r, done_r, err_ovf_r;
    logic             accept_s, cap_hit_s, last_beat_s, flush_s;
    logic [A_W-1:0]   a_in_s [N];
    logic [B_W-1:0]   b_in_s [N];

    // in_ready_r is high exactly while the FSM is in FEED.
    assign accept_s    = in_valid && in_ready_r;
    assign cap_hit_s   = (beat_cnt_r == LAST_BEAT);
    assign last_beat_s = in_last || cap_hit_s;

    // Next-state decode for the job sequencer
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) next_s = ST_CLEAR;
                else       next_s = ST_IDLE;
            end
            ST_CLEAR: next_s = ST_FEED;
            ST_FEED: begin
                if (accept_s && last_beat_s) next_s = ST_DRAIN;
                else                         next_s = ST_FEED;
            end
            ST_DRAIN: begin
                if (drain_cnt_r == DRAIN_LAST) next_s = ST_DRAIN == ST_DRAIN ? ST_DONE : ST_DONE;
                else                           next_s = ST_DRAIN;
            end
            ST_DONE: next_s = ST_IDLE;
            default: next_s = ST_IDLE;
        endcase
    end

    // State register plus control outputs registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            clr_r      <= 1'b0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= next_s;
            clr_r      <= (next_s == ST_CLEAR);
            in_ready_r <= (next_s == ST_FEED);
            busy_r     <= (next_s != ST_IDLE);
            done_r     <= (next_s == ST_DONE);
        end
    end

    // Count accepted beats per job and flag a job that hits K_MAX without in_last
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_r <= {CNT_W{1'b0}};
            err_ovf_r  <= 1'b0;
        end else if (state_r == ST_CLEAR) begin
            beat_cnt_r <= {CNT_W{1'b0}};
            err_ovf_r  <= 1'b0;
        end else if (accept_s) begin
            beat_cnt_r <= beat_cnt_r + CNT_W'(1);
            err_ovf_r  <= err_ovf_r | (cap_hit_s & ~in_last);
        end else begin
            beat_cnt_r <= beat_cnt_r;
            err_ovf_r  <= err_ovf_r;
        end
    end

    // Time the drain window so the last beat crosses the whole array before DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            drain_cnt_r <= {DR_W{1'b0}};
        end else if (state_r == ST_DRAIN) begin
            drain_cnt_r <= drain_cnt_r + DR_W'(1);
        end else begin
            drain_cnt_r <= {DR_W{1'b0}};
        end
    end

    // Lane input mux: an accepted beat enters the line; any other cycle injects a zero bubble
    always_comb begin
        for (int i = 0; i < N; i++) begin
            if (accept_s) begin
                a_in_s[i] = a_col[i];
                b_in_s[i] = b_row[i];
            end else begin
                a_in_s[i] = {A_W{1'b0}};
                b_in_s[i] = {B_W{1'b0}};
            end
        end
    end

    // Empty the skew lines on entry to CLEAR so they hold zero for the whole CLEAR cycle.
    assign flush_s = (next_s == ST_CLEAR);

    for (genvar g = 0; g < N; g++) begin : g_lane
        skew_line #(.DEPTH(g + 1), .WIDTH(A_W)) u_a_line (
            .clk   (clk),
            .rst   (rst),
            .flush (flush_s),
            .din   (a_in_s[g]),
            .dout  (left[g])
        );
        skew_line #(.DEPTH(g + 1), .WIDTH(B_W)) u_b_line (
            .clk   (clk),
            .rst   (rst),
            .flush (flush_s),
            .din   (b_in_s[g]),
            .dout  (top[g])
        );
    end

`ifdef SYSARRAY_FEEDER_STALL_CNT_EN
    logic [15:0] stall_cnt_r;

    // Count FEED cycles without an accepted beat; saturate at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 16'h0000;
        end else if (state_r == ST_CLEAR) begin
            stall_cnt_r <= 16'h0000;
        end else if (in_ready_r && !in_valid && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'h0001;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`else
    assign stall_cnt = 16'h0000;
`endif

    assign in_ready = in_ready_r;
    assign clr      = clr_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign err_ovf  = err_ovf_r;

endmodule

// File: tb/tb_sysarray_feeder.sv
// Testbench for sysarray_feeder.
// It drives the feeder from a scoreboard and checks the skewed lane timing.
// A behavioural 3x3 output-stationary array computes C = A*B downstream of the feeder.
module tb_sysarray_feeder;

    localparam int DRAIN = 6;
    localparam int KMAX  = 4;
`ifdef SYSARRAY_FEEDER_STALL_CNT_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic              clk;
    logic              rst, start, in_valid, in_ready, in_last;
    logic signed [7:0] a_col [0:2];
    logic signed [7:0] b_row [0:2];
    logic signed [7:0] left  [0:2];
    logic signed [7:0] top   [0:2];
    logic              clr, busy, done, err_ovf;
    logic [15:0]       stall_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;
    int done_pulses = 0;

    int          ma [0:2][0:3];
    int          mb [0:3][0:2];
    int          exp_q [$];
    logic [47:0] skew_q [$];

    // Downstream array model state
    logic signed [7:0] pe_a [0:2][0:2];
    logic signed [7:0] pe_b [0:2][0:2];
    int                acc  [0:2][0:2];

    sysarray_feeder #(.A_W(8), .B_W(8), .K_MAX(KMAX), .DRAIN_CYC(DRAIN)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .a_col(a_col), .b_row(b_row), .in_last(in_last), .left(left), .top(top),
        .clr(clr), .busy(busy), .done(done), .err_ovf(err_ovf), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (done === 1'b1) done_pulses <= done_pulses + 1;

    function automatic logic signed [7:0] a_in(int i, int j);
        if (j == 0) return left[i];
        return pe_a[i][j-1];
    endfunction

    function automatic logic signed [7:0] b_in(int i, int j);
        if (i == 0) return top[j];
        return pe_b[i-1][j];
    endfunction

    // Behavioural output-stationary PE grid
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                pe_a[i][j] <= a_in(i, j);
                pe_b[i][j] <= b_in(i, j);
                if (rst || clr) acc[i][j] <= 0;
                else acc[i][j] <= acc[i][j] + int'(a_in(i, j)) * int'(b_in(i, j));
            end
        end
    end

    function automatic logic [47:0] lanes();
        return {left[0], left[1], left[2], top[0], top[1], top[2]};
    endfunction

    task automatic clear_inputs();
        in_valid = 1'b0;
        in_last  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_col[i] = 8'sd0;
            b_row[i] = 8'sd0;
        end
    endtask

    task automatic wait_ready(output bit ok);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        ok = (in_ready === 1'b1);
    endtask

    task automatic run_job(input int kb, input int gap, input bit mark_last, input bit exp_ovf);
        int  n, sc, d0, s, got;
        bit  ok;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                s = 0;
                for (int k = 0; k < kb; k++) s += ma[i][k] * mb[k][j];
                exp_q.push_back(s);
            end
        d0 = done_pulses;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        sc = cyc;
        total_cnt++;
        if (clr !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1)
            $display("FAIL clear_state: clr=%b in_ready=%b busy=%b expected 1 0 1", clr, in_ready, busy);
        else pass_cnt++;
        for (int k = 0; k < kb; k++) begin
            wait_ready(ok);
            for (int i = 0; i < 3; i++) begin
                a_col[i] = 8'(ma[i][k]);
                b_row[i] = 8'(mb[k][i]);
            end
            in_valid = 1'b1;
            in_last  = mark_last && (k == kb - 1);
            @(posedge clk); #1;
            clear_inputs();
            if (k == 0) repeat (gap) begin @(posedge clk); #1; end
        end
        n = 0;
        while (done !== 1'b1 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        total_cnt++;
        if (done !== 1'b1) $display("FAIL done_timeout: done=%b after %0d cycles, expected 1", done, n);
        else if (cyc - sc != 1 + kb + gap + DRAIN)
            $display("FAIL done_latency: got %0d cycles expected %0d", cyc - sc, 1 + kb + gap + DRAIN);
        else pass_cnt++;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                s = exp_q.pop_front();
                got = acc[i][j];
                total_cnt++;
                if (got !== s) $display("FAIL out[%0d]: got %0d expected %0d", i * 3 + j, got, s);
                else pass_cnt++;
            end
        total_cnt++;
        if (err_ovf !== exp_ovf) $display("FAIL err_ovf: got %b expected %b", err_ovf, exp_ovf);
        else pass_cnt++;
        total_cnt++;
        if (stall_cnt !== (STALL_EN ? 16'(gap) : 16'd0))
            $display("FAIL stall_cnt: got %0d expected %0d", stall_cnt, STALL_EN ? gap : 0);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL done_width: done=%b busy=%b expected 0 0", done, busy);
        else pass_cnt++;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if (done_pulses - d0 != 1) $display("FAIL done_count: got %0d expected 1", done_pulses - d0);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if ({busy, in_ready, clr, done, err_ovf} !== 5'b00000)
            $display("FAIL reset_ctrl: got %b expected 00000", {busy, in_ready, clr, done, err_ovf});
        else pass_cnt++;
        total_cnt++;
        if (stall_cnt !== 16'd0) $display("FAIL reset_stall: got %0d expected 0", stall_cnt);
        else pass_cnt++;
        total_cnt++;
        if (lanes() !== 48'd0) $display("FAIL reset_lanes: got %h expected 0", lanes());
        else pass_cnt++;
        rst = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_idle: busy=%b expected 0", busy);
        else pass_cnt++;
    endtask

    task automatic load_identity();
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 4; k++) begin
                ma[i][k] = (k < 3 && i == k) ? 1 : 0;
                mb[k][i] = (k < 3) ? k * 3 + i + 1 : 0;
            end
    endtask

    task automatic test_identity();
        load_identity();
        run_job(3, 0, 1'b1, 1'b0);
    endtask

    task automatic test_bubbles();
        load_identity();
        run_job(3, 2, 1'b1, 1'b0);
    endtask

    task automatic test_skew();
        bit ok;
        int n;
        skew_q.push_back({8'd1, 8'd0, 8'd0, 8'd4, 8'd0, 8'd0});
        skew_q.push_back({8'd0, 8'd2, 8'd0, 8'd0, 8'd5, 8'd0});
        skew_q.push_back({8'd0, 8'd0, 8'd3, 8'd0, 8'd0, 8'd6});
        skew_q.push_back(48'd0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_ready(ok);
        a_col[0] = 8'sd1; a_col[1] = 8'sd2; a_col[2] = 8'sd3;
        b_row[0] = 8'sd4; b_row[1] = 8'sd5; b_row[2] = 8'sd6;
        in_valid = 1'b1;
        in_last  = 1'b1;
        @(posedge clk); #1;
        clear_inputs();
        for (int c = 0; c < 4; c++) begin
            logic [47:0] e;
            e = skew_q.pop_front();
            total_cnt++;
            if (lanes() !== e) $display("FAIL skew_t%0d: got %h expected %h", c + 1, lanes(), e);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        n = 0;
        while (busy === 1'b1 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 4; k++) begin
                ma[i][k] = i + k + 1;
                mb[k][i] = k - i - 1;
            end
        run_job(KMAX, 0, 1'b0, 1'b1);
    endtask

    task automatic test_signed();
        bit ok;
        int d0;
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 4; k++) begin
                ma[i][k] = (k < 3) ? -128 : 0;
                mb[k][i] = (k < 3) ? -128 : 0;
            end
        run_job(3, 0, 1'b1, 1'b0);
        // Abandon a job mid-FEED with reset
        d0 = done_pulses;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_ready(ok);
        for (int i = 0; i < 3; i++) begin
            a_col[i] = -8'sd128;
            b_row[i] = -8'sd128;
        end
        in_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_inputs();
        total_cnt++;
        if ({busy, in_ready, clr} !== 3'b000 || lanes() !== 48'd0)
            $display("FAIL midrst_state: busy=%b in_ready=%b clr=%b lanes=%h expected 0", busy, in_ready, clr, lanes());
        else pass_cnt++;
        repeat (20) @(posedge clk);
        #1;
        total_cnt++;
        if (done_pulses != d0) $display("FAIL midrst_done: got %0d pulses expected 0", done_pulses - d0);
        else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        clear_inputs();
        test_reset();
        test_identity();
        test_skew();
        test_bubbles();
        test_overflow();
        test_signed();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
